// File: rtl/trace_capture.sv
// ============================================================================
// Module   : trace_capture
// Brief    : Arm/trigger execution-trace recorder with a 4-word stream drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trace_capture #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                pc_in,
    input  logic [31:0]                instr_in,
    input  logic [31:0]                alu_in,
    input  logic [3:0]                 flags_in,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       trig_any,
    input  logic [31:0]                trig_pc,
    input  logic [7:0]                 cap_len,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = DEPTH[AW:0];

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    // entry layout: {seq, flags, alu, instr, pc}
    logic [107:0]    r_mem [DEPTH];
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [31:0]     r_last_pc;
    logic [7:0]      r_remaining;
    logic [7:0]      r_seq;
    logic [7:0]      r_drop_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [1:0]      r_word_idx;

    logic            w_sample;
    logic            w_trig_hit;
    logic            w_ctrl;
    logic            w_cap_en;
    logic            w_capture;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [107:0]    w_head;

    assign w_sample   = (pc_in != r_last_pc);
    assign w_trig_hit = trig_any || (pc_in == trig_pc);
    assign w_ctrl     = clear || stop || arm;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = r_state;
        end else if (stop) begin
            w_state_next = c_ST_IDLE;
        end else if (arm) begin
            w_state_next = c_ST_ARMED;
        end else begin
            case (r_state)
                c_ST_ARMED: begin
                    if (w_sample && w_trig_hit) begin
                        w_state_next = (cap_len == 8'd1) ? c_ST_DONE : c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    // remaining == 0 while capturing means an unlimited run
                    if (w_sample && (r_remaining == 8'd1)) begin
                        w_state_next = c_ST_DONE;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_cap_en = 1'b0;
        state_o  = r_state;
        case (r_state)
            c_ST_ARMED:   w_cap_en = w_trig_hit;
            c_ST_CAPTURE: w_cap_en = 1'b1;
            default:      w_cap_en = 1'b0;
        endcase
    end

    assign w_capture = w_sample && w_cap_en && !w_ctrl;
    assign w_pop     = out_valid && out_ready && (r_word_idx == 2'd3);
    assign w_push    = w_capture && ((r_level < c_FULL) || w_pop);
    assign w_drop    = w_capture && !w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_pc   <= 32'hFFFF_FFFF;
            r_remaining <= 8'd0;
        end else begin
            if (!clear && !stop && arm) begin
                r_last_pc <= 32'hFFFF_FFFF;
            end else if (w_sample) begin
                r_last_pc <= pc_in;
            end
            if (w_capture) begin
                if (r_state == c_ST_ARMED) begin
                    r_remaining <= (cap_len == 8'd0) ? 8'd0 : cap_len - 8'd1;
                end else if (r_remaining != 8'd0) begin
                    r_remaining <= r_remaining - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_word_idx <= 2'd0;
            r_seq      <= 8'd0;
            r_drop_cnt <= 8'd0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_word_idx <= 2'd0;
            r_seq      <= 8'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_seq    <= r_seq + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (out_valid && out_ready) begin
                r_word_idx <= r_word_idx + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_seq, flags_in, alu_in, instr_in, pc_in};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        out_data = 32'd0;
        if (out_valid) begin
            case (r_word_idx)
                2'd0:    out_data = w_head[31:0];
                2'd1:    out_data = w_head[63:32];
                2'd2:    out_data = w_head[95:64];
                default: out_data = {20'h0, w_head[107:96]};
            endcase
        end
    end

    assign out_valid = (r_level != '0);
    assign out_last  = out_valid && (r_word_idx == 2'd3);
    assign level     = r_level;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture.sv
// ============================================================================
// Module   : tb_trace_capture
// Brief    : Directed table-driven and sequence checks for trace_capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trace_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [31:0] alu_in;
    logic [3:0]  flags_in;
    logic        arm, stop, clear, trig_any;
    logic [31:0] trig_pc;
    logic [7:0]  cap_len;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_last;
    logic [1:0]  state_o;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Core model: instruction/ALU/flags derived from the PC
    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return 32'hE000_0000 | pc;
    endfunction
    function automatic logic [31:0] f_alu(input logic [31:0] pc);
        return pc + 32'h0001_0000;
    endfunction
    function automatic logic [3:0] f_flags(input logic [31:0] pc);
        return pc[5:2] ^ 4'hA;
    endfunction

    assign instr_in = f_instr(pc_in);
    assign alu_in   = f_alu(pc_in);
    assign flags_in = f_flags(pc_in);

    trace_capture #(.DEPTH(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .instr_in (instr_in),
        .alu_in   (alu_in),
        .flags_in (flags_in),
        .arm      (arm),
        .stop     (stop),
        .clear    (clear),
        .trig_any (trig_any),
        .trig_pc  (trig_pc),
        .cap_len  (cap_len),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .state_o  (state_o),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        arm;
        logic        clr;
        logic        rdy;
        logic [31:0] pc;
        logic [1:0]  e_state;
        logic [4:0]  e_level;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
    } vec_t;

    vec_t vt [10];

    initial begin
        // trig_any=1, cap_len=3 capture followed by drain and clear
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 32'h00,  2'd2, 5'd1, 1'b1, 32'h0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 32'h04,  2'd2, 5'd2, 1'b1, 32'h0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 32'h08,  2'd3, 5'd3, 1'b1, 32'h0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0C,  2'd3, 5'd3, 1'b1, 32'h0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 32'h0C,  2'd3, 5'd3, 1'b1, 32'hE000_0000, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 32'h0C,  2'd3, 5'd3, 1'b1, 32'h0001_0000, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 32'h0C,  2'd3, 5'd3, 1'b1, 32'h0000_000A, 1'b1};
        vt[8] = '{1'b0, 1'b0, 1'b1, 32'h0C,  2'd3, 5'd2, 1'b1, 32'h0000_0004, 1'b0};
        vt[9] = '{1'b0, 1'b1, 1'b0, 32'h0C,  2'd3, 5'd0, 1'b0, 32'h0, 1'b0};

        rst = 1'b0; pc_in = 32'h100; arm = 0; stop = 0; clear = 0;
        trig_any = 1'b1; trig_pc = 32'h0; cap_len = 8'd3; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_drop",  {24'd0, drop_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            arm = vt[i].arm; clear = vt[i].clr; out_ready = vt[i].rdy; pc_in = vt[i].pc;
            tick();
            chk($sformatf("vec%0d_state", i), {30'd0, state_o}, {30'd0, vt[i].e_state});
            chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vt[i].e_level});
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
            chk($sformatf("vec%0d_last", i), {31'd0, out_last}, {31'd0, vt[i].e_last});
        end
        arm = 0; clear = 0; out_ready = 0;

        // Address trigger, then a stalled PC
        trig_any = 1'b0; trig_pc = 32'h20; cap_len = 8'd0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("tpc_armed", {30'd0, state_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h10 + 32'(4 * i);
            tick();
        end
        chk("tpc_pre_level", {27'd0, level}, 32'd0);
        chk("tpc_pre_state", {30'd0, state_o}, 32'd1);
        pc_in = 32'h20;
        tick();
        chk("tpc_state", {30'd0, state_o}, 32'd2);
        chk("tpc_level", {27'd0, level}, 32'd1);
        chk("tpc_data",  out_data, 32'h20);
        pc_in = 32'h40;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_level", {27'd0, level}, 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_state", {30'd0, state_o}, 32'd0);

        // Overflow with drops, then simultaneous pop and push when full
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_state_kept", {30'd0, state_o}, 32'd0);
        trig_any = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pc_in = 32'h1000 + 32'(4 * i);
            tick();
        end
        chk("full_level", {27'd0, level}, 32'd16);
        chk("full_drop",  {24'd0, drop_cnt}, 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("full_meta", out_data, 32'h0000_000A);
        chk("full_last", {31'd0, out_last}, 32'd1);
        pc_in = 32'h2000;
        tick();
        chk("popush_level", {27'd0, level}, 32'd16);
        chk("popush_drop",  {24'd0, drop_cnt}, 32'd4);
        chk("popush_data",  out_data, 32'h1004);

        // out_ready toggling: each word held while stalled
        begin
            logic [31:0] exp_d [8];
            logic        exp_l [8];
            exp_d = '{32'h1004, f_instr(32'h1004), f_instr(32'h1004), f_alu(32'h1004),
                      f_alu(32'h1004), 32'h0000_001B, 32'h0000_001B, 32'h1008};
            exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 8; i++) begin
                out_ready = (i % 2 == 1);
                tick();
                chk($sformatf("tog%0d_data", i), out_data, exp_d[i]);
                chk($sformatf("tog%0d_last", i), {31'd0, out_last}, {31'd0, exp_l[i]});
            end
        end
        chk("tog_level", {27'd0, level}, 32'd15);

        // Mid-drain clear
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("mclr_level", {27'd0, level}, 32'd0);
        chk("mclr_valid", {31'd0, out_valid}, 32'd0);
        chk("mclr_data",  out_data, 32'd0);
        chk("mclr_drop",  {24'd0, drop_cnt}, 32'd0);
        chk("mclr_state", {30'd0, state_o}, 32'd2);
        for (int i = 0; i < 17; i++) begin
            pc_in = 32'h3000 + 32'(4 * i);
            tick();
        end
        chk("refill_level", {27'd0, level}, 32'd16);
        chk("refill_drop",  {24'd0, drop_cnt}, 32'd1);
        chk("refill_data",  out_data, 32'h3000);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_level", {27'd0, level}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_drop",  {24'd0, drop_cnt}, 32'd0);
        chk("arst_state", {30'd0, state_o}, 32'd0);
        chk("arst_data",  out_data, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
